// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction fetch unit: FSM states, fault causes
// and the instruction size used for the alignment check.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10,
        ST_FAULT = 2'b11
    } fetch_state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_TIMEOUT  = 2'b10
    } fault_cause_e;

    localparam int INSTR_BYTES = 4;

    // A target is misaligned when any byte-offset bit below the word size is set.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        logic [1:0] mask;
        mask = 2'(INSTR_BYTES - 1);
        return (addr_lsb & mask) != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles a fetch request waits without acknowledge and flags the edge
// on which the wait reaches MAX_WAIT cycles.
module fetch_timeout_ctr #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_W'(MAX_WAIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expiry fires on the edge that would make the count reach MAX_WAIT, so the
    // request has then been high for exactly MAX_WAIT cycles without an ack.
    always_comb begin
        expired = enable && !clear && (cnt_q == CNT_W'(MAX_WAIT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Architectural PC register and instruction fetch sequencer: loads NextPC on
// advance, fetches the word over req/ack and hands it to decode with a valid.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 15
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [ADDR_W-1:0]  NextPC,
    input  logic               advance,
    output logic [ADDR_W-1:0]  CurrentPC,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               fetch_fault,
    output logic [1:0]         fault_cause,
    output fetch_state_e       state_dbg
);

    // Memory handshake: imem_req is registered and, while high, imem_addr is
    // stable; a transfer completes on the first rising edge where imem_req and
    // imem_ack are both high. imem_ack while imem_req is low is ignored.

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               req_q, req_d;
    logic               fault_q, fault_d;
    fault_cause_e       cause_q, cause_d;

    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;

    fetch_timeout_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timeout (
        .clk     (CLK),
        .rst     (Reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        req_d      = req_q;
        fault_d    = fault_q;
        cause_d    = cause_q;
        tmo_clear  = 1'b1;
        tmo_enable = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                addr_d  = pc_q;
            end

            ST_FETCH: begin
                tmo_clear  = imem_ack;
                tmo_enable = !imem_ack;
                // Ack wins over a timeout landing on the same edge.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_HOLD;
                end else if (tmo_expired) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    cause_d = FC_TIMEOUT;
                    state_d = ST_FAULT;
                end
            end

            ST_HOLD: begin
                if (advance) begin
                    pc_d    = NextPC;
                    valid_d = 1'b0;
                    if (is_misaligned(NextPC[1:0])) begin
                        fault_d = 1'b1;
                        cause_d = FC_MISALIGN;
                        state_d = ST_FAULT;
                    end else begin
                        req_d   = 1'b1;
                        addr_d  = NextPC;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_FAULT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end

            default: begin
                state_d = ST_FAULT;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= FC_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    assign CurrentPC   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign fetch_fault = fault_q;
    assign fault_cause = cause_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot fetch, advance, delayed ack,
// timeout fault, misaligned fault and asynchronous reset mid-fetch.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int              ADDR_W   = 64;
    localparam int              INSTR_W  = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = 64'h0;
    localparam int              MAX_WAIT = 15;

    logic               CLK;
    logic               Reset;
    logic [ADDR_W-1:0]  NextPC;
    logic               advance;
    logic [ADDR_W-1:0]  CurrentPC;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               fetch_fault;
    logic [1:0]         fault_cause;
    fetch_state_e       state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RESET_PC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .NextPC      (NextPC),
        .advance     (advance),
        .CurrentPC   (CurrentPC),
        .instr       (instr),
        .instr_valid (instr_valid),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .fetch_fault (fetch_fault),
        .fault_cause (fault_cause),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // From BOOT with reset released: two edges to the first ack-capable cycle,
    // then a one-cycle ack carrying rdata.
    task automatic boot_to_hold(input logic [INSTR_W-1:0] rdata);
        tick();
        tick();
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        tick();
        imem_ack   = 1'b0;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        if (RESET_PC[1:0] != 2'b00) $fatal(1, "RESET_PC must be word aligned");

        Reset      = 1'b1;
        NextPC     = '0;
        advance    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        tick();
        tick();

        // reset state
        check_eq("rst_pc",    CurrentPC,   RESET_PC);
        check_eq("rst_addr",  imem_addr,   RESET_PC);
        check_eq("rst_instr", instr,       0);
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_req",   imem_req,    0);
        check_eq("rst_fault", fetch_fault, 0);
        check_eq("rst_cause", fault_cause, 0);
        check_eq("rst_state", state_dbg,   ST_BOOT);

        // 1: boot fetch with 1-cycle memory
        Reset = 1'b0;
        tick();                                   // edge 1
        check_eq("t1_req_e1",   imem_req,    1);
        check_eq("t1_addr_e1",  imem_addr,   64'h0);
        check_eq("t1_valid_e1", instr_valid, 0);
        tick();                                   // edge 2: memory sees req
        check_eq("t1_valid_e2", instr_valid, 0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hF84003E0;
        tick();                                   // edge 3
        imem_ack   = 1'b0;
        check_eq("t1_instr",    instr,       32'hF84003E0);
        check_eq("t1_valid_e3", instr_valid, 1);
        check_eq("t1_req_e3",   imem_req,    0);
        check_eq("t1_pc",       CurrentPC,   64'h0);
        tick();
        tick();
        check_eq("t1_hold_valid", instr_valid, 1);
        check_eq("t1_hold_state", state_dbg,   ST_HOLD);

        // 2: advance to 0x4
        NextPC  = 64'h4;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        check_eq("t2_pc",    CurrentPC,   64'h4);
        check_eq("t2_addr",  imem_addr,   64'h4);
        check_eq("t2_req",   imem_req,    1);
        check_eq("t2_valid", instr_valid, 0);

        // 3: ack delayed 5 cycles; advance during FETCH is ignored
        for (int i = 0; i < 5; i++) begin
            advance = (i == 0);
            NextPC  = 64'h999;
            tick();
            advance = 1'b0;
            check_eq($sformatf("t3_addr_%0d", i),  imem_addr,   64'h4);
            check_eq($sformatf("t3_req_%0d", i),   imem_req,    1);
            check_eq($sformatf("t3_fault_%0d", i), fetch_fault, 0);
        end
        check_eq("t3_pc_ign", CurrentPC, 64'h4);
        imem_ack   = 1'b1;
        imem_rdata = 32'h12345678;
        tick();
        imem_ack   = 1'b0;
        check_eq("t3_instr", instr,       32'h12345678);
        check_eq("t3_valid", instr_valid, 1);
        check_eq("t3_req",   imem_req,    0);

        // 4: timeout at 0x8 after MAX_WAIT cycles of req without ack
        NextPC  = 64'h8;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        check_eq("t4_req_start", imem_req, 1);
        repeat (MAX_WAIT - 1) tick();
        check_eq("t4_nofault_pre", fetch_fault, 0);
        check_eq("t4_req_pre",     imem_req,    1);
        tick();
        check_eq("t4_fault", fetch_fault, 1);
        check_eq("t4_cause", fault_cause, 2'b10);
        check_eq("t4_req",   imem_req,    0);
        check_eq("t4_pc",    CurrentPC,   64'h8);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        tick();
        tick();
        imem_ack   = 1'b0;
        check_eq("t4_sticky_fault", fetch_fault, 1);
        check_eq("t4_sticky_cause", fault_cause, 2'b10);
        check_eq("t4_sticky_valid", instr_valid, 0);
        check_eq("t4_sticky_req",   imem_req,    0);
        pulse_reset();
        check_eq("t4_rst_fault", fetch_fault, 0);

        // 5: misaligned target
        boot_to_hold(32'hA5A5A5A5);
        check_eq("t5_valid_pre", instr_valid, 1);
        NextPC  = 64'h102;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        check_eq("t5_fault", fetch_fault, 1);
        check_eq("t5_cause", fault_cause, 2'b01);
        check_eq("t5_pc",    CurrentPC,   64'h102);
        check_eq("t5_req",   imem_req,    0);
        check_eq("t5_valid", instr_valid, 0);
        tick();
        tick();
        check_eq("t5_req_later", imem_req,  0);
        check_eq("t5_state",     state_dbg, ST_FAULT);
        pulse_reset();

        // 6: reset mid-FETCH at 0x40; ack during and after reset ignored
        boot_to_hold(32'h0BADF00D);
        NextPC  = 64'h40;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        check_eq("t6_req",  imem_req,  1);
        check_eq("t6_addr", imem_addr, 64'h40);
        #2;
        Reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFEF00D;
        #1;
        check_eq("t6_async_req", imem_req,  0);
        check_eq("t6_async_pc",  CurrentPC, RESET_PC);
        tick();
        Reset = 1'b0;
        tick();                                   // BOOT -> FETCH with ack still high
        check_eq("t6_boot_valid", instr_valid, 0);
        check_eq("t6_boot_instr", instr,       0);
        check_eq("t6_boot_req",   imem_req,    1);
        imem_ack = 1'b0;
        tick();
        check_eq("t6_after_valid", instr_valid, 0);
        check_eq("t6_after_pc",    CurrentPC,   RESET_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
